// File: rtl/timed_delay_queue.sv
`default_nettype none
// ============================================================================
// Module   : timed_delay_queue
// Purpose  : In-order FIFO where every entry carries its own release delay.
//            An entry pushed with delay D becomes visible at the output
//            max(D,1) cycles after its push edge. Entries leave strictly in
//            push order, so a matured entry waits behind an unmatured head.
// Ports    : clk        - single clock, rising-edge
//            rst_n      - asynchronous active-low reset
//            in_valid   - upstream offers an entry
//            in_ready   - queue can store an entry (not full)
//            in_data    - entry payload
//            in_delay   - requested delay for this entry
//            out_valid  - head entry stored and matured
//            out_ready  - downstream takes the head entry
//            out_data   - head entry payload
//            count      - number of stored entries (0..DEPTH)
// Revision : 1.0 - initial release
// ============================================================================
module timed_delay_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int DLY_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [DLY_W-1:0]           in_delay,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  logic [WIDTH-1:0]   r_data [DEPTH];
  logic [DLY_W-1:0]   r_rem  [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;

  logic               w_push;
  logic               w_pop;
  logic [DLY_W-1:0]   w_load_rem;

  // Flow control is derived from stored state only; a pop in the same cycle
  // never opens a slot for a push when the queue is full.
  assign in_ready  = (r_count != c_CNT_W'(DEPTH));
  assign out_valid = (r_count != '0) && (r_rem[r_rd_ptr] == '0);
  assign out_data  = r_data[r_rd_ptr];
  assign count     = r_count;

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  // The push edge itself counts as the first cycle of the delay, so the
  // counter starts at D-1; D=0 behaves like D=1.
  assign w_load_rem = (in_delay == '0) ? '0 : (in_delay - 1'b1);

  // Remaining-cycle counters: every slot ticks down toward zero each edge.
  // Slots that hold no entry also tick, which is harmless because a push
  // always reloads the slot it writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_rem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_push && (r_wr_ptr == c_PTR_W'(i))) begin
          r_rem[i] <= w_load_rem;
        end else if (r_rem[i] != '0) begin
          r_rem[i] <= r_rem[i] - 1'b1;
        end
      end
    end
  end

  // Payload storage needs no reset: a slot is only read once count covers it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_push && (r_wr_ptr == c_PTR_W'(i))) begin
        r_data[i] <= in_data;
      end
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; the extra count
  // bit tells full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_timed_delay_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_timed_delay_queue
// Purpose  : Directed scoreboard bench for timed_delay_queue. Drivers push
//            expected payloads and release cycles into a queue; a monitor on
//            the falling edge pops and compares on every output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_timed_delay_queue;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int DLY_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic [DLY_W-1:0] in_delay = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [$clog2(DEPTH):0] count;

  timed_delay_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DLY_W(DLY_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_delay  (in_delay),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  // Edge counter: after rising edge n (read #1 later or at the falling edge)
  // cyc equals n.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: payload, release cycle, and whether that cycle is exact
  // (free-flowing output) or only a lower bound (backpressure in play).
  logic [WIDTH-1:0] sb_data [$];
  int               sb_cyc  [$];
  bit               sb_exact[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  logic [WIDTH-1:0] m_data;
  int               m_cyc;
  bit               m_exact;
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb_data.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_out: got data 0x%0h at cycle %0d, expected no entry", out_data, cyc);
      end else if (out_ready) begin
        m_data  = sb_data.pop_front();
        m_cyc   = sb_cyc.pop_front();
        m_exact = sb_exact.pop_front();
        check("out_data", out_data, m_data);
        if (m_exact) check("out_cycle", cyc, m_cyc);
        else         check("out_not_early", 32'(cyc >= m_cyc), 32'd1);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offers one entry for one edge; in_valid is left high so callers can push
  // on consecutive edges.
  task automatic push(input logic [WIDTH-1:0] d, input int dly, input bit exact);
    in_valid = 1'b1;
    in_data  = d;
    in_delay = DLY_W'(dly);
    check("in_ready_before_push", in_ready, 1'b1);
    @(posedge clk);
    #1;
    sb_data.push_back(d);
    sb_cyc.push_back(cyc + ((dly > 1) ? dly : 1) - 1);
    sb_exact.push_back(exact);
  endtask

  task automatic wait_empty(input int bound);
    int k;
    k = 0;
    while (count != 0 && k < bound) begin
      step(1);
      k++;
    end
    check("drain_within_bound", 32'(count), 32'd0);
  endtask

  int p;
  bit ok;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(1);

    // Single entry, D=10, single-cycle pulse 10 cycles after push
    out_ready = 1'b1;
    push(32'hDEADBEEF, 10, 1'b1);
    in_valid = 1'b0;
    p = cyc;
    step(8);
    check("d10_not_yet", out_valid, 1'b0);
    step(1);
    check("d10_rise", out_valid, 1'b1);
    check("d10_data", out_data, 32'hDEADBEEF);
    step(1);
    check("d10_pulse_end", out_valid, 1'b0);
    check("d10_count", 32'(count), 32'd0);

    // D=0 then D=1 back to back; second push coincides with first pop
    push(32'h0000_00A0, 0, 1'b1);
    push(32'h0000_00B1, 1, 1'b1);
    in_valid = 1'b0;
    check("simul_push_pop_count", 32'(count), 32'd1);
    step(1);
    check("b2b_count", 32'(count), 32'd0);

    // Head-of-line blocking: A (D=20) holds back B (D=1)
    push(32'h0000_0A20, 20, 1'b1);
    p = cyc;
    push(32'h0000_0B01, 1, 1'b1);
    in_valid = 1'b0;
    sb_cyc[sb_cyc.size()-1] = p + 20;
    step(9);
    check("hol_blocked", out_valid, 1'b0);
    wait_empty(40);

    // Fill to DEPTH under backpressure, hold 100 cycles, drain in 8
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) push(32'h100 + i, 5, 1'b0);
    in_valid = 1'b0;
    check("full_in_ready", in_ready, 1'b0);
    check("full_count", 32'(count), 32'd8);
    ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (!(out_valid === 1'b1 && out_data === 32'h100 && count == 8)) ok = 1'b0;
    end
    check("backpressure_hold", ok, 1'b1);
    out_ready = 1'b1;
    step(8);
    check("drain_8_cycles", 32'(count), 32'd0);

    // Full queue with simultaneous offer and take: only the pop happens
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) push(32'h200 + i, 1, 1'b0);
    in_valid  = 1'b1;
    in_data   = 32'hBAD0_0001;
    in_delay  = 8'd1;
    out_ready = 1'b1;
    step(1);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("full_simul_count", 32'(count), 32'd7);
    check("full_simul_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    wait_empty(20);

    // Asynchronous reset mid-operation discards stored entries
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(32'h300 + i, 2, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 1'b0);
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_in_ready", in_ready, 1'b1);
    sb_data.delete();
    sb_cyc.delete();
    sb_exact.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    push(32'h0000_0055, 1, 1'b1);
    in_valid = 1'b0;
    check("push_after_reset_count", 32'(count), 32'd1);
    step(30);
    check("post_reset_empty", 32'(count), 32'd0);

    check("scoreboard_empty", 32'(sb_data.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/timed_delay_queue.md
TIMED_DELAY_QUEUE -- requirements
Module: timed_delay_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, entry count (power of two, >=2).
REQ-003 SHALL have parameter DLY_W, default 8, width of the per-entry delay field.
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  upstream offers an entry.
REQ-007 SHALL have port in_ready  output  1  queue accepts an entry this cycle.
REQ-008 SHALL have port in_data  input  WIDTH  entry payload.
REQ-009 SHALL have port in_delay  input  DLY_W  requested delay D in cycles for this entry.
REQ-010 SHALL have port out_valid  output  1  head entry is matured and offered.
REQ-011 SHALL have port out_ready  input  1  downstream takes the head entry.
REQ-012 SHALL have port out_data  output  WIDTH  head entry payload.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  number of stored entries.

Function
REQ-014 SHALL accept an entry on a rising edge where in_valid && in_ready (push); SHALL drop nothing.
REQ-015 SHALL release an entry on a rising edge where out_valid && out_ready (pop).
REQ-016 SHALL drive in_ready = (count != DEPTH), combinationally from state only; in_ready SHALL NOT depend on out_ready (no full-bypass).
REQ-017 SHALL store per entry: payload and a remaining-cycle counter rem (DLY_W bits); on push, rem SHALL load max(D-1, 0).
REQ-018 SHALL decrement, on every rising edge, rem of every stored entry with rem > 0; rem SHALL saturate at 0 and SHALL remain 0 thereafter.
REQ-019 SHALL drive out_valid = (count != 0) && (head rem == 0), combinationally from state.
REQ-020 SHALL give latency max(D,1) cycles: entry pushed on edge k with delay D first presents out_valid in the cycle following edge k+max(D,1)-1.
REQ-021 SHALL release entries strictly in push order; a matured entry behind an unmatured head SHALL wait (head-of-line blocking).
REQ-022 SHALL hold out_valid high and out_data stable while out_ready is low (backpressure), for any duration.
REQ-023 SHALL present out_data = head payload whenever out_valid is 1; value when out_valid is 0 is don't-care.
REQ-024 SHALL, on simultaneous push and pop, keep count unchanged and apply both; the pushed entry SHALL NOT bypass to the output in the same cycle.
REQ-025 SHALL use wrap-around read/write pointers of $clog2(DEPTH) bits; count SHALL distinguish full (DEPTH) from empty (0).
REQ-026 SHALL ignore in_data/in_delay when no push occurs and out_ready when out_valid is 0.
REQ-027 SHALL be fully synthesizable: no delay controls, no initial blocks for state.

Reset
REQ-028 SHALL, while rst_n is 0, force count=0, pointers=0, out_valid=0, in_ready=1, regardless of clk.
REQ-029 SHALL discard all stored entries when rst_n asserts mid-operation; no entry pushed before reset SHALL appear after release.
REQ-030 SHALL accept a push on the first rising edge after rst_n deasserts.

Verification
REQ-031 SHALL pass: push data 0xDEADBEEF with D=10, out_ready=1 -> out_valid rises exactly 10 cycles after push edge, single-cycle pulse, data 0xDEADBEEF.
REQ-032 SHALL pass: push D=0 then D=1 on consecutive edges -> each presented 1 cycle after its push, back-to-back, in order.
REQ-033 SHALL pass: push A (D=20) then B (D=1) -> B held until A pops at 20 cycles; B valid the cycle after A pops.
REQ-034 SHALL pass: push 8 entries (DEPTH=8) with D=5, out_ready=0 -> in_ready=0 after 8th push, count=8, out_valid held high with stable data for 100 cycles; then out_ready=1 drains all 8 in 8 cycles in order.
REQ-035 SHALL pass: full queue, out_ready=1 and in_valid=1 same cycle -> one pop only, count=7 next cycle, in_ready=1.
REQ-036 SHALL pass: 3 entries stored, rst_n pulsed low asynchronously between edges -> out_valid=0, count=0 immediately; no stale entry ever emerges.
